// File: rtl/demux_1x4_n_seq.sv
// Receive-side 1-to-4 time-division demultiplexer: collects four BITS-wide words
// into shadow slots and publishes them atomically on D0..D3 once a frame is complete.
module demux_1x4_n_seq #(
    parameter int BITS = 4,
    parameter int CW   = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [BITS-1:0] DIN,
    input  logic            DIN_VALID,
    input  logic            CLEAR,
    output logic [1:0]      SEL_OUT,
    output logic [BITS-1:0] D0,
    output logic [BITS-1:0] D1,
    output logic [BITS-1:0] D2,
    output logic [BITS-1:0] D3,
    output logic            FRAME_DONE,
    output logic            BUSY,
    output logic [CW-1:0]   FRAME_COUNT
);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    logic [1:0]      slot_q, slot_d;
    logic [BITS-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [BITS-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        slot_d = slot_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        d0_d   = d0_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        d3_d   = d3_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        // CLEAR dominates DIN_VALID, so a word arriving with CLEAR never completes a frame
        if (CLEAR) begin
            slot_d = SLOT0;
        end else if (DIN_VALID) begin
            case (slot_q)
                SLOT0: begin
                    s0_d   = DIN;
                    slot_d = SLOT1;
                end
                SLOT1: begin
                    s1_d   = DIN;
                    slot_d = SLOT2;
                end
                SLOT2: begin
                    s2_d   = DIN;
                    slot_d = SLOT3;
                end
                default: begin
                    d0_d   = s0_q;
                    d1_d   = s1_q;
                    d2_d   = s2_q;
                    d3_d   = DIN;
                    done_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    slot_d = SLOT0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= SLOT0;
            s0_q   <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            d3_q   <= d3_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    assign SEL_OUT     = slot_q;
    assign BUSY        = (slot_q != SLOT0);
    assign D0          = d0_q;
    assign D1          = d1_q;
    assign D2          = d2_q;
    assign D3          = d3_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_COUNT = cnt_q;

endmodule
